pico_fetch: RTL and testbench

Instruction fetch stage for the PicoMIPS core. It owns the program counter, drives the synchronous program ROM address, and presents one 24-bit instruction per cycle to the decoder. It applies the decoder's `modePC` command (halt, increment, relative, absolute) on each accepted instruction and keeps a retired-instruction count.

---
 rtl/pico_pkg.sv | 21 ++
 rtl/pico_pc_next.sv | 38 +++
 rtl/pico_fetch.sv | 79 +++++++
 tb/tb_pico_fetch.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pico_pkg.sv
// Shared PicoMIPS types and constants for the fetch stage.
// The optional resume feature is enabled by defining PICO_FETCH_RESUME_EN.
package pico;

    parameter int A  = 10;
    parameter int IC = 16;

    typedef enum logic [1:0] {
        HALTCOUNT = 2'd0,
        INCREMENT = 2'd1,
        RELATIVE  = 2'd2,
        ABSOLUTE  = 2'd3
    } modePC;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetchState;

endpackage

// File: rtl/pico_pc_next.sv
// Next-PC computation for the fetch stage: branch/jump target and halt detection.
// Purely combinational; the ROM address path runs straight through here.
module pico_pc_next
    import pico::*;
#(
    parameter int A = pico::A
) (
    input  logic [A-1:0] fpc,
    input  modePC        pc_mode,
    input  logic [7:0]   imm,
    input  logic         accept,
    input  fetchState    state,
    output logic [A-1:0] target,
    output logic         halt_enter
);

    logic [A-1:0] imm_sext;
    logic [A-1:0] imm_zext;

    assign imm_sext = {{(A-8){imm[7]}}, imm};
    assign imm_zext = {{(A-8){1'b0}}, imm};

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        target     = fpc;
        halt_enter = 1'b0;
        if (state == RUN && accept) begin
            case (pc_mode)
                INCREMENT: target = fpc + 1'b1;
                RELATIVE:  target = fpc + imm_sext;
                ABSOLUTE:  target = imm_zext;
                HALTCOUNT: halt_enter = 1'b1;
                default:   target = fpc;
            endcase
        end
    end

endmodule

// File: rtl/pico_fetch.sv
// PicoMIPS instruction fetch: owns the PC, drives the synchronous ROM, counts retirements.
// Define PICO_FETCH_RESUME_EN to add the resume input that restarts fetch after HALTCOUNT.
module pico_fetch
    import pico::*;
#(
    parameter int          A            = pico::A,
    parameter int          W            = 24,
    parameter logic [A-1:0] RESET_VECTOR = '0
) (
    input  logic          clk,
    input  logic          nReset,
    output logic [A-1:0]  mem_addr,
    input  logic [W-1:0]  mem_data,
    output logic [W-1:0]  inst,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [A-1:0]  pc,
    input  modePC         pc_mode,
    input  logic [7:0]    imm,
    output logic          halted,
    output logic [IC-1:0] icount
`ifdef PICO_FETCH_RESUME_EN
    ,
    input  logic          resume
`endif
);

    fetchState    state;
    logic [A-1:0] fpc;
    logic [A-1:0] target;
    logic         halt_enter;
    logic         accept;
    logic         resume_go;

    assign inst_valid = (state == RUN);
    assign halted     = (state == HALTED);
    assign accept     = inst_valid & inst_ready;
    assign inst       = inst_valid ? mem_data : '0;
    assign pc         = fpc;

`ifdef PICO_FETCH_RESUME_EN
    assign resume_go = halted & resume;
`else
    assign resume_go = 1'b0;
`endif

    pico_pc_next #(.A(A)) u_pc_next (
        .fpc        (fpc),
        .pc_mode    (pc_mode),
        .imm        (imm),
        .accept     (accept),
        .state      (state),
        .target     (target),
        .halt_enter (halt_enter)
    );

    // The ROM always reads what fpc will hold next, so its data lines up with fpc.
    assign mem_addr = resume_go ? fpc + 1'b1 : target;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state  <= FILL;
            fpc    <= RESET_VECTOR;
            icount <= '0;
        end else begin
            fpc <= mem_addr;
            if (accept && icount != '1)
                icount <= icount + 1'b1;
            case (state)
                FILL:    state <= RUN;
                RUN:     if (halt_enter) state <= HALTED;
                HALTED:  if (resume_go) state <= RUN;
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_pico_fetch.sv
// Directed, table-driven bench for pico_fetch with a behavioural synchronous ROM.
// Builds with or without PICO_FETCH_RESUME_EN.
module tb_pico_fetch;
    import pico::*;

    localparam int A = 10;
    localparam int W = 24;

    logic          clk;
    logic          nReset;
    logic [A-1:0]  mem_addr;
    logic [W-1:0]  mem_data;
    logic [W-1:0]  inst;
    logic          inst_valid;
    logic          inst_ready;
    logic [A-1:0]  pc;
    modePC         pc_mode;
    logic [7:0]    imm;
    logic          halted;
    logic [IC-1:0] icount;
`ifdef PICO_FETCH_RESUME_EN
    logic          resume;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] rom [0:(1<<A)-1];

    pico_fetch #(.A(A), .W(W), .RESET_VECTOR('0)) dut (
        .clk        (clk),
        .nReset     (nReset),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .pc         (pc),
        .pc_mode    (pc_mode),
        .imm        (imm),
        .halted     (halted),
        .icount     (icount)
`ifdef PICO_FETCH_RESUME_EN
        ,
        .resume     (resume)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) mem_data <= rom[mem_addr];

    typedef struct {
        logic          ready;
        modePC         mode;
        logic [7:0]    imm;
        logic          exp_valid;
        logic [A-1:0]  exp_pc;
        logic [IC-1:0] exp_icount;
        logic [A-1:0]  exp_ma;
        logic          exp_halted;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs [NV];

    function automatic logic [W-1:0] rom_word(input logic [A-1:0] a);
        return 24'h5A0000 | {14'd0, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " inst_valid"}, 32'(inst_valid), 32'(v.exp_valid));
        check({tag, " pc"},         32'(pc),         32'(v.exp_pc));
        check({tag, " icount"},     32'(icount),     32'(v.exp_icount));
        check({tag, " mem_addr"},   32'(mem_addr),   32'(v.exp_ma));
        check({tag, " halted"},     32'(halted),     32'(v.exp_halted));
        check({tag, " inst"},       32'(inst),
              32'(v.exp_valid ? rom_word(v.exp_pc) : 24'd0));
    endtask

    // Drive on the falling edge, compare 1 ns later, then let the rising edge happen.
    task automatic run_step(input string tag, input vec_t v);
        @(negedge clk);
        inst_ready = v.ready;
        pc_mode    = v.mode;
        imm        = v.imm;
        #1;
        check_outputs(tag, v);
        @(posedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 nReset = 1'b1;
    endtask

    vec_t v;

    initial begin
        for (int i = 0; i < (1 << A); i++) rom[i] = rom_word(A'(i));

        //           ready mode       imm    valid pc      icount ma      halted
        vecs[0]  = '{1'b1, INCREMENT, 8'h00, 1'b0, 10'h000, 16'd0,  10'h000, 1'b0}; // FILL
        vecs[1]  = '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h000, 16'd0,  10'h001, 1'b0};
        vecs[2]  = '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h001, 16'd1,  10'h002, 1'b0};
        vecs[3]  = '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h002, 16'd2,  10'h003, 1'b0};
        vecs[4]  = '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h003, 16'd3,  10'h004, 1'b0};
        vecs[5]  = '{1'b0, ABSOLUTE,  8'hEE, 1'b1, 10'h004, 16'd4,  10'h004, 1'b0}; // stall x3
        vecs[6]  = '{1'b0, RELATIVE,  8'h33, 1'b1, 10'h004, 16'd4,  10'h004, 1'b0};
        vecs[7]  = '{1'b0, HALTCOUNT, 8'h00, 1'b1, 10'h004, 16'd4,  10'h004, 1'b0};
        vecs[8]  = '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h004, 16'd4,  10'h005, 1'b0};
        vecs[9]  = '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h005, 16'd5,  10'h006, 1'b0};
        vecs[10] = '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h006, 16'd6,  10'h007, 1'b0};
        vecs[11] = '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h007, 16'd7,  10'h008, 1'b0};
        vecs[12] = '{1'b1, RELATIVE,  8'hFD, 1'b1, 10'h008, 16'd8,  10'h005, 1'b0}; // bne -3
        vecs[13] = '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h005, 16'd9,  10'h006, 1'b0};
        vecs[14] = '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h006, 16'd10, 10'h007, 1'b0};
        vecs[15] = '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h007, 16'd11, 10'h008, 1'b0};
        vecs[16] = '{1'b1, RELATIVE,  8'hFD, 1'b1, 10'h008, 16'd12, 10'h005, 1'b0}; // bne -3
        vecs[17] = '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h005, 16'd13, 10'h006, 1'b0};
        vecs[18] = '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h006, 16'd14, 10'h007, 1'b0};
        vecs[19] = '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h007, 16'd15, 10'h008, 1'b0};
        vecs[20] = '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h008, 16'd16, 10'h009, 1'b0}; // fall through
        vecs[21] = '{1'b1, ABSOLUTE,  8'h10, 1'b1, 10'h009, 16'd17, 10'h010, 1'b0};
        vecs[22] = '{1'b1, ABSOLUTE,  8'hF0, 1'b1, 10'h010, 16'd18, 10'h0F0, 1'b0};
        vecs[23] = '{1'b1, ABSOLUTE,  8'h02, 1'b1, 10'h0F0, 16'd19, 10'h002, 1'b0};
        vecs[24] = '{1'b1, RELATIVE,  8'h80, 1'b1, 10'h002, 16'd20, 10'h382, 1'b0}; // wraps down
        vecs[25] = '{1'b1, RELATIVE,  8'h7D, 1'b1, 10'h382, 16'd21, 10'h3FF, 1'b0};
        vecs[26] = '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h3FF, 16'd22, 10'h000, 1'b0}; // wraps up
        vecs[27] = '{1'b1, ABSOLUTE,  8'h09, 1'b1, 10'h000, 16'd23, 10'h009, 1'b0};
        vecs[28] = '{1'b1, HALTCOUNT, 8'h00, 1'b1, 10'h009, 16'd24, 10'h009, 1'b0};
        vecs[29] = '{1'b1, INCREMENT, 8'h00, 1'b0, 10'h009, 16'd25, 10'h009, 1'b1};
        vecs[30] = '{1'b0, ABSOLUTE,  8'h44, 1'b0, 10'h009, 16'd25, 10'h009, 1'b1};

        nReset     = 1'b0;
        inst_ready = 1'b1;
        pc_mode    = INCREMENT;
        imm        = 8'h00;
`ifdef PICO_FETCH_RESUME_EN
        resume     = 1'b0;
`endif

        // Reset state, checked while reset is held.
        #12;
        v = '{1'b1, INCREMENT, 8'h00, 1'b0, 10'h000, 16'd0, 10'h000, 1'b0};
        check_outputs("reset", v);

        release_reset();
        for (int i = 0; i < NV; i++) run_step($sformatf("vec%0d", i), vecs[i]);

`ifdef PICO_FETCH_RESUME_EN
        // Resume from HALTED at 9: address 10 goes out immediately, valid next cycle.
        resume = 1'b1;
        run_step("resume_req", '{1'b1, INCREMENT, 8'h00, 1'b0, 10'h009, 16'd25, 10'h00A, 1'b1});
        resume = 1'b0;
        run_step("resume_run", '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h00A, 16'd25, 10'h00B, 1'b0});
        resume = 1'b1;
        run_step("resume_ign", '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h00B, 16'd26, 10'h00C, 1'b0});
        resume = 1'b0;
`else
        run_step("halt_hold", '{1'b1, RELATIVE, 8'h05, 1'b0, 10'h009, 16'd25, 10'h009, 1'b1});
`endif

        // Restart, run to pc=6, then drop nReset mid-cycle.
        @(negedge clk);
        nReset = 1'b0;
        #1;
        release_reset();
        run_step("rst2_fill", '{1'b1, INCREMENT, 8'h00, 1'b0, 10'h000, 16'd0, 10'h000, 1'b0});
        for (int i = 0; i < 6; i++)
            run_step($sformatf("rst2_run%0d", i),
                     '{1'b1, INCREMENT, 8'h00, 1'b1, A'(i), 16'(i), A'(i + 1), 1'b0});
        @(negedge clk);
        #1;
        check("pre_async pc", 32'(pc), 32'h6);
        #1 nReset = 1'b0;
        #1;
        check_outputs("async_rst", '{1'b1, INCREMENT, 8'h00, 1'b0, 10'h000, 16'd0, 10'h000, 1'b0});
        @(posedge clk);
        #1;
        check_outputs("rst_held", '{1'b1, INCREMENT, 8'h00, 1'b0, 10'h000, 16'd0, 10'h000, 1'b0});

        release_reset();
        run_step("rst3_fill", '{1'b1, INCREMENT, 8'h00, 1'b0, 10'h000, 16'd0, 10'h000, 1'b0});
        run_step("rst3_run0", '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h000, 16'd0, 10'h001, 1'b0});
        run_step("rst3_run1", '{1'b1, INCREMENT, 8'h00, 1'b1, 10'h001, 16'd1, 10'h002, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
